// File: rtl/hs4_sync_receiver.sv
// hs4_sync_receiver
//   Receiving end of a 4-phase (return-to-zero) bundled-data handshake.
//   The asynchronous request is synchronised into the clk domain. Each
//   complete handshake pushes one bundled word into a small circular FIFO.
//   The FIFO head is presented on a valid/ready interface to clocked logic.
//
// Parameters
//   DATA_W      width of the bundled data word
//   DEPTH       FIFO entries (power of 2, >= 2)
//   SYNC_STAGES flops in the req_in synchroniser (>= 2)
//
// Ports
//   clk, rst_n   system clock; asynchronous active-low reset
//   req_in       4-phase request from upstream (asynchronous to clk)
//   data_in      bundled data, stable while req_in is high until ack_out rises
//   ack_out      registered 4-phase acknowledge to upstream
//   dout         FIFO head word (holds the last popped word when empty)
//   dout_valid   FIFO not empty
//   dout_ready   consumer accepts dout this cycle
//   fifo_level   current occupancy
//
// Optional feature (macro HS4_XFER_CNT_EN)
//   xfer_cnt     16-bit wrapping count of pushes
//   stall_seen   sticky flag: a request was seen while the FIFO was full

module hs4_sync_receiver #(
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack_out,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
`ifdef HS4_XFER_CNT_EN
    output logic [15:0]                xfer_cnt,
    output logic [0:0]                 stall_seen,
`endif
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        rd_prev;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    req_s;
    logic                    full;
    logic                    push;
    logic                    pop;
`ifdef HS4_XFER_CNT_EN
    logic [15:0]             xfer_cnt_q, xfer_cnt_d;
    logic                    stall_seen_q, stall_seen_d;
`endif

    assign req_s = sync_q[SYNC_STAGES-1];
    // Full test uses the registered level, so a same-cycle pop never
    // makes room for a push; the push follows one cycle later.
    assign full  = (level_q == FULL_LVL);
    assign push  = (state_q == IDLE) && req_s && !full;
    assign pop   = (level_q != '0) && dout_ready;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], req_in};
        state_d  = state_q;
        ack_d    = ack_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (push) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

`ifdef HS4_XFER_CNT_EN
    always_comb begin
        xfer_cnt_d   = xfer_cnt_q + (push ? 16'd1 : 16'd0);
        stall_seen_d = stall_seen_q | ((state_q == IDLE) && req_s && full);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            sync_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            sync_q   <= sync_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

`ifdef HS4_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q   <= '0;
            stall_seen_q <= 1'b0;
        end else begin
            xfer_cnt_q   <= xfer_cnt_d;
            stall_seen_q <= stall_seen_d;
        end
    end

    assign xfer_cnt   = xfer_cnt_q;
    assign stall_seen = stall_seen_q;
`endif

    // When empty, show the slot behind the read pointer: the last word
    // popped (all zero after reset, since storage is cleared).
    assign rd_prev    = rd_ptr_q - PTR_W'(1);
    assign dout       = (level_q == '0) ? mem_q[rd_prev] : mem_q[rd_ptr_q];
    assign dout_valid = (level_q != '0);
    assign ack_out    = ack_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_hs4_sync_receiver.sv
module tb_hs4_sync_receiver;

    logic       clk;
    logic       rst_n;
    logic       req_in;
    logic [1:0] data_in;
    logic       ack_out;
    logic [1:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] fifo_level;
`ifdef HS4_XFER_CNT_EN
    logic [15:0] xfer_cnt;
    logic [0:0]  stall_seen;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hs4_sync_receiver #(
        .DATA_W      (2),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef HS4_XFER_CNT_EN
        .xfer_cnt   (xfer_cnt),
        .stall_seen (stall_seen),
`endif
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full 4-phase handshake; checks both latencies are 3 edges.
    task automatic handshake(input logic [1:0] d, input string tag);
        int n;
        data_in = d;
        req_in  = 1'b1;
        n = 0;
        while (ack_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_rise_lat"}, n, 3);
        req_in = 1'b0;
        n = 0;
        while (ack_out !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_fall_lat"}, n, 3);
    endtask

    initial begin
        logic [1:0] exp_seq [4];
        rst_n      = 1'b0;
        req_in     = 1'b0;
        data_in    = 2'b00;
        dout_ready = 1'b0;
        step();
        step();
        check("rst_ack",   ack_out,    0);
        check("rst_valid", dout_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_dout",  dout,       0);
`ifdef HS4_XFER_CNT_EN
        check("rst_xfer",  xfer_cnt,   0);
        check("rst_stall", stall_seen, 0);
`endif
        rst_n = 1'b1;
        step();

        // Single transfer: ack rises on the third edge with the word visible.
        data_in = 2'b10;
        req_in  = 1'b1;
        step();
        step();
        check("t1_ack_e2", ack_out, 0);
        step();
        check("t1_ack_e3",  ack_out,    1);
        check("t1_dout",    dout,       2'b10);
        check("t1_valid",   dout_valid, 1);
        check("t1_level",   fifo_level, 1);
        req_in = 1'b0;
        step();
        step();
        check("t1_ack_hold", ack_out, 1);
        step();
        check("t1_ack_fall", ack_out, 0);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("t1_pop_level", fifo_level, 0);
        check("t1_pop_valid", dout_valid, 0);
        check("t1_hold_dout", dout,       2'b10);

        // Fill to full, then a stalled fifth request.
        handshake(2'b00, "hs0");
        handshake(2'b01, "hs1");
        handshake(2'b10, "hs2");
        handshake(2'b11, "hs3");
        check("full_level", fifo_level, 4);
        check("full_head",  dout,       2'b00);
        data_in = 2'b01;
        req_in  = 1'b1;
        repeat (6) step();
        check("stall_ack",   ack_out,    0);
        check("stall_level", fifo_level, 4);
`ifdef HS4_XFER_CNT_EN
        check("stall_seen", stall_seen, 1);
        check("xfer_5",     xfer_cnt,   5);
`endif
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        check("pop_full_level", fifo_level, 3);
        check("pop_full_ack",   ack_out,    0);
        check("pop_full_head",  dout,       2'b01);
        step();
        check("fifth_ack",   ack_out,    1);
        check("fifth_level", fifo_level, 4);
`ifdef HS4_XFER_CNT_EN
        check("xfer_6", xfer_cnt, 6);
`endif
        req_in = 1'b0;
        repeat (3) step();
        check("fifth_ack_fall", ack_out, 0);

        // Drain: remaining order 01,10,11 then the fifth word 01.
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b11;
        exp_seq[3] = 2'b01;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), dout_valid, 1);
            check($sformatf("drain_dout%0d", i),  dout,       exp_seq[i]);
            step();
        end
        check("drain_valid_end", dout_valid, 0);
        check("drain_level_end", fifo_level, 0);
        check("drain_hold",      dout,       2'b01);
        step();
        check("empty_pop_level", fifo_level, 0);
        dout_ready = 1'b0;

        // Simultaneous push and pop at level 2.
        handshake(2'b11, "pp0");
        handshake(2'b00, "pp1");
        check("pp_level2", fifo_level, 2);
        data_in = 2'b10;
        req_in  = 1'b1;
        step();
        step();
        dout_ready = 1'b1;
        step();
        check("pp_ack",   ack_out,    1);
        check("pp_level", fifo_level, 2);
        check("pp_head",  dout,       2'b00);
        req_in = 1'b0;
        step();
        check("pp_head2",  dout,       2'b10);
        check("pp_level1", fifo_level, 1);
        step();
        dout_ready = 1'b0;
        check("pp_level0", fifo_level, 0);
        step();
        check("pp_ack_fall", ack_out, 0);
`ifdef HS4_XFER_CNT_EN
        check("xfer_9", xfer_cnt, 9);
`endif

        // Reset while in ACK, then recapture with req_in still high.
        data_in = 2'b11;
        req_in  = 1'b1;
        repeat (3) step();
        check("mr_ack_pre",   ack_out,    1);
        check("mr_level_pre", fifo_level, 1);
        rst_n = 1'b0;
        #1;
        check("mr_ack_async",   ack_out,    0);
        check("mr_level_async", fifo_level, 0);
        check("mr_valid_async", dout_valid, 0);
`ifdef HS4_XFER_CNT_EN
        check("mr_xfer",  xfer_cnt,   0);
        check("mr_stall", stall_seen, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        step();
        check("mr_ack_e2", ack_out, 0);
        step();
        check("mr_ack_e3", ack_out,    1);
        check("mr_level",  fifo_level, 1);
        check("mr_dout",   dout,       2'b11);
`ifdef HS4_XFER_CNT_EN
        check("mr_xfer1", xfer_cnt, 1);
`endif
        req_in = 1'b0;
        repeat (3) step();
        check("mr_ack_fall", ack_out, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
